// File: rtl/cve2_trace_pkg.sv
// Shared types for the cve2 RVFI trace buffer: record layout, filter modes,
// trigger states and the record filter predicate.
package cve2_trace_pkg;

    // One captured retirement, MSB to LSB as it appears on trace_rec_o.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic        trap;
        logic        intr;
        logic        gap;
    } trace_rec_t;

    localparam int unsigned TraceRecW = $bits(trace_rec_t);

    typedef enum logic [1:0] {
        TrAll   = 2'd0,
        TrMem   = 2'd1,
        TrCtrl  = 2'd2,
        TrRegWr = 2'd3
    } trace_filter_e;

    typedef enum logic [1:0] {
        TrigIdle    = 2'd0,
        TrigRun     = 2'd1,
        TrigStopped = 2'd2
    } trig_state_e;

    // Decides whether a retirement is interesting under the selected mode.
    // Control-flow mode flags anything that did not fall through to pc+4
    // (the addition wraps at 2^32 like the core's own PC).
    function automatic logic trace_filter_hit(
        input trace_filter_e mode,
        input logic [31:0]   pc_rdata,
        input logic [31:0]   pc_wdata,
        input logic [4:0]    rd_addr,
        input logic [3:0]    rmask,
        input logic [3:0]    wmask,
        input logic          trap,
        input logic          intr
    );
        logic hit;
        hit = 1'b1;
        case (mode)
            TrAll:   hit = 1'b1;
            TrMem:   hit = |(rmask | wmask);
            TrCtrl:  hit = trap | intr | (pc_wdata != (pc_rdata + 32'd4));
            TrRegWr: hit = (rd_addr != 5'd0);
            default: hit = 1'b1;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/cve2_trace_fifo.sv
// Generic synchronous FIFO. Full/empty come from an occupancy counter, so
// pointers are plain log2(Depth)-bit wrapping counters. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module cve2_trace_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth + 1);
    localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [LvlW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DepthLvl);
    assign level_o = count_q;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head is forced to zero when empty so stale or uninitialised storage
    // never shows on the output.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage write port.
    // NOTE: the data array has no reset; validity is tracked by count_q, and
    // leaving it unreset lets it map onto plain flops/RAM without a reset tree.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cve2_rvfi_trace_buffer.sv
// On-chip trace capture for cve2: filters the RVFI retirement stream, gates it
// with a PC start/stop trigger, buffers accepted records in a FIFO and drains
// them over a valid/ready stream. Records that find the FIFO full are counted
// and the next stored record is marked with gap=1.
module cve2_rvfi_trace_buffer
    import cve2_trace_pkg::*;
#(
    parameter int unsigned Depth   = 16,
    parameter int unsigned OvfCntW = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       rvfi_valid,
    input  logic [31:0]                rvfi_insn,
    input  logic                       rvfi_trap,
    input  logic                       rvfi_intr,
    input  logic [31:0]                rvfi_pc_rdata,
    input  logic [31:0]                rvfi_pc_wdata,
    input  logic [4:0]                 rvfi_rd_addr,
    input  logic [31:0]                rvfi_rd_wdata,
    input  logic [31:0]                rvfi_mem_addr,
    input  logic [3:0]                 rvfi_mem_rmask,
    input  logic [3:0]                 rvfi_mem_wmask,
    input  logic                       trace_en_i,
    input  logic [1:0]                 filter_mode_i,
    input  logic                       trig_en_i,
    input  logic [31:0]                trig_start_pc_i,
    input  logic [31:0]                trig_stop_pc_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output trace_rec_t                 trace_rec_o,
    output logic [$clog2(Depth+1)-1:0] fill_level_o,
    output logic [OvfCntW-1:0]         ovf_cnt_o,
    output trig_state_e                trig_state_o
);

    trig_state_e           state_q, state_d;
    logic                  trig_eligible;
    logic                  filter_hit;
    logic                  start_hit;
    logic                  stop_hit;
    logic                  capture;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  gap_pending_q;
    logic [OvfCntW-1:0]    ovf_cnt_q;
    trace_rec_t            rec_in;
    logic [TraceRecW-1:0]  fifo_rdata;

    assign filter_hit = trace_filter_hit(trace_filter_e'(filter_mode_i), rvfi_pc_rdata,
                                         rvfi_pc_wdata, rvfi_rd_addr, rvfi_mem_rmask,
                                         rvfi_mem_wmask, rvfi_trap, rvfi_intr);
    assign start_hit  = (rvfi_pc_rdata == trig_start_pc_i);
    assign stop_hit   = (rvfi_pc_rdata == trig_stop_pc_i);

    // Trigger next state and whether the current retirement lies inside the
    // capture window (start and stop records are both inclusive).
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        trig_eligible = 1'b0;
        if (!trace_en_i) begin
            state_d = TrigIdle;
        end else if (rvfi_valid) begin
            if (!trig_en_i) begin
                state_d       = TrigRun;
                trig_eligible = (state_q != TrigStopped);
            end else begin
                case (state_q)
                    TrigIdle: begin
                        if (start_hit) begin
                            trig_eligible = 1'b1;
                            state_d       = stop_hit ? TrigStopped : TrigRun;
                        end
                    end
                    TrigRun: begin
                        trig_eligible = 1'b1;
                        if (stop_hit) begin
                            state_d = TrigStopped;
                        end
                    end
                    TrigStopped: state_d = TrigStopped;
                    default:     state_d = TrigIdle;
                endcase
            end
        end
    end

    // Trigger state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TrigIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign pop     = trace_valid_o & trace_ready_i;
    assign capture = rvfi_valid & trace_en_i & filter_hit & trig_eligible;
    assign push    = capture & (~fifo_full | pop);
    assign drop    = capture & fifo_full & ~pop;

    // Assemble the record to store; gap marks that records were lost before it.
    always_comb begin
        rec_in          = '0;
        rec_in.pc       = rvfi_pc_rdata;
        rec_in.insn     = rvfi_insn;
        rec_in.rd_addr  = rvfi_rd_addr;
        rec_in.rd_wdata = rvfi_rd_wdata;
        rec_in.mem_addr = rvfi_mem_addr;
        rec_in.rmask    = rvfi_mem_rmask;
        rec_in.wmask    = rvfi_mem_wmask;
        rec_in.trap     = rvfi_trap;
        rec_in.intr     = rvfi_intr;
        rec_in.gap      = gap_pending_q;
    end

    // Overflow accounting: saturating drop counter and pending-gap flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_cnt_q     <= '0;
            gap_pending_q <= 1'b0;
        end else begin
            if (drop && (ovf_cnt_q != '1)) begin
                ovf_cnt_q <= ovf_cnt_q + 1'b1;
            end
            if (push) begin
                gap_pending_q <= 1'b0;
            end else if (drop) begin
                gap_pending_q <= 1'b1;
            end
        end
    end

    cve2_trace_fifo #(
        .Depth (Depth),
        .Width (TraceRecW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (rec_in),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fill_level_o)
    );

    assign trace_valid_o = ~fifo_empty;
    assign trace_rec_o   = trace_rec_t'(fifo_rdata);
    assign ovf_cnt_o     = ovf_cnt_q;
    assign trig_state_o  = state_q;

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// Self-checking bench for cve2_rvfi_trace_buffer: a vector table for the
// single-cycle filter behaviour plus directed sequences for trigger, overflow,
// gap marking, full-with-pop and asynchronous reset.
module tb_cve2_rvfi_trace_buffer;
    import cve2_trace_pkg::*;

    localparam int unsigned Depth   = 16;
    localparam int unsigned OvfCntW = 16;

    logic              clk_i;
    logic              rst_ni;
    logic              rvfi_valid;
    logic [31:0]       rvfi_insn;
    logic              rvfi_trap;
    logic              rvfi_intr;
    logic [31:0]       rvfi_pc_rdata;
    logic [31:0]       rvfi_pc_wdata;
    logic [4:0]        rvfi_rd_addr;
    logic [31:0]       rvfi_rd_wdata;
    logic [31:0]       rvfi_mem_addr;
    logic [3:0]        rvfi_mem_rmask;
    logic [3:0]        rvfi_mem_wmask;
    logic              trace_en_i;
    logic [1:0]        filter_mode_i;
    logic              trig_en_i;
    logic [31:0]       trig_start_pc_i;
    logic [31:0]       trig_stop_pc_i;
    logic              trace_valid_o;
    logic              trace_ready_i;
    trace_rec_t        trace_rec_o;
    logic [4:0]        fill_level_o;
    logic [OvfCntW-1:0] ovf_cnt_o;
    trig_state_e       trig_state_o;

    cve2_rvfi_trace_buffer #(
        .Depth   (Depth),
        .OvfCntW (OvfCntW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rvfi_valid      (rvfi_valid),
        .rvfi_insn       (rvfi_insn),
        .rvfi_trap       (rvfi_trap),
        .rvfi_intr       (rvfi_intr),
        .rvfi_pc_rdata   (rvfi_pc_rdata),
        .rvfi_pc_wdata   (rvfi_pc_wdata),
        .rvfi_rd_addr    (rvfi_rd_addr),
        .rvfi_rd_wdata   (rvfi_rd_wdata),
        .rvfi_mem_addr   (rvfi_mem_addr),
        .rvfi_mem_rmask  (rvfi_mem_rmask),
        .rvfi_mem_wmask  (rvfi_mem_wmask),
        .trace_en_i      (trace_en_i),
        .filter_mode_i   (filter_mode_i),
        .trig_en_i       (trig_en_i),
        .trig_start_pc_i (trig_start_pc_i),
        .trig_stop_pc_i  (trig_stop_pc_i),
        .trace_valid_o   (trace_valid_o),
        .trace_ready_i   (trace_ready_i),
        .trace_rec_o     (trace_rec_o),
        .fill_level_o    (fill_level_o),
        .ovf_cnt_o       (ovf_cnt_o),
        .trig_state_o    (trig_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total;
    int bad;

    typedef struct {
        logic        v;
        logic [1:0]  mode;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic [31:0] maddr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        int          exp_level;
        logic [3:0]  exp_wm;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic retire(input logic v, input logic [31:0] pc, input logic [31:0] npc,
                          input logic [4:0] rd, input logic [31:0] maddr,
                          input logic [3:0] rm, input logic [3:0] wm);
        rvfi_valid     = v;
        rvfi_pc_rdata  = pc;
        rvfi_pc_wdata  = npc;
        rvfi_insn      = insn_of(pc);
        rvfi_rd_addr   = rd;
        rvfi_rd_wdata  = pc + 32'h11;
        rvfi_mem_addr  = maddr;
        rvfi_mem_rmask = rm;
        rvfi_mem_wmask = wm;
    endtask

    task automatic idle_in();
        retire(1'b0, 32'h0, 32'h4, 5'd0, 32'h0, 4'h0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] mode, input logic [31:0] pc,
                                input logic [31:0] npc, input logic [4:0] rd,
                                input logic [31:0] maddr, input logic [3:0] rm,
                                input logic [3:0] wm, input logic ev, input int lvl);
        vec_t r;
        r.v = v; r.mode = mode; r.pc = pc; r.npc = npc; r.rd = rd; r.maddr = maddr;
        r.rm = rm; r.wm = wm; r.ready = 1'b1; r.exp_valid = ev; r.exp_pc = pc;
        r.exp_level = lvl; r.exp_wm = wm; r.exp_maddr = maddr;
        return r;
    endfunction

    initial begin
        logic [31:0] trig_pcs [5];
        trig_state_e trig_exp [5];
        int          trig_lvl [5];

        total = 0;
        bad   = 0;
        rst_ni          = 1'b0;
        trace_en_i      = 1'b0;
        filter_mode_i   = 2'd0;
        trig_en_i       = 1'b0;
        trig_start_pc_i = 32'h0;
        trig_stop_pc_i  = 32'h0;
        trace_ready_i   = 1'b0;
        rvfi_trap       = 1'b0;
        rvfi_intr       = 1'b0;
        idle_in();

        // Reset state, observed before any clock edge.
        #3;
        check("rst_valid", trace_valid_o, 0);
        check("rst_rec", trace_rec_o, 0);
        check("rst_level", fill_level_o, 0);
        check("rst_ovf", ovf_cnt_o, 0);
        check("rst_state", trig_state_o, TrigIdle);
        @(posedge clk_i);
        #1;
        rst_ni     = 1'b1;
        trace_en_i = 1'b1;

        // Mode 0: back-to-back, each visible one cycle after retirement.
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1'b1, 2'd0, 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i),
                              5'd1, 32'h0, 4'h0, 4'h0, 1'b1, 1));
        end
        vecs.push_back(mk(1'b0, 2'd0, 32'h0, 32'h4, 5'd0, 32'h0, 4'h0, 4'h0, 1'b0, 0));
        // Mode 1: ALU, LW, SW, ALU -> only memory ops.
        vecs.push_back(mk(1'b1, 2'd1, 32'h200, 32'h204, 5'd1, 32'h0, 4'h0, 4'h0, 1'b0, 0));
        vecs.push_back(mk(1'b1, 2'd1, 32'h204, 32'h208, 5'd2, 32'h2000, 4'hF, 4'h0, 1'b1, 1));
        vecs.push_back(mk(1'b1, 2'd1, 32'h208, 32'h20C, 5'd0, 32'h1000, 4'h0, 4'hF, 1'b1, 1));
        vecs.push_back(mk(1'b1, 2'd1, 32'h20C, 32'h210, 5'd3, 32'h0, 4'h0, 4'h0, 1'b0, 0));
        // Mode 2: sequential miss, taken branch hit, wrap-around sequential miss.
        vecs.push_back(mk(1'b1, 2'd2, 32'h300, 32'h304, 5'd1, 32'h0, 4'h0, 4'h0, 1'b0, 0));
        vecs.push_back(mk(1'b1, 2'd2, 32'h304, 32'h400, 5'd1, 32'h0, 4'h0, 4'h0, 1'b1, 1));
        vecs.push_back(mk(1'b1, 2'd2, 32'hFFFF_FFFC, 32'h0, 5'd1, 32'h0, 4'h0, 4'h0, 1'b0, 0));
        // Mode 3: x0 destination ignored, real register write captured.
        vecs.push_back(mk(1'b1, 2'd3, 32'h500, 32'h504, 5'd0, 32'h0, 4'h0, 4'h0, 1'b0, 0));
        vecs.push_back(mk(1'b1, 2'd3, 32'h504, 32'h508, 5'd7, 32'h0, 4'h0, 4'h0, 1'b1, 1));
        vecs.push_back(mk(1'b0, 2'd3, 32'h0, 32'h4, 5'd0, 32'h0, 4'h0, 4'h0, 1'b0, 0));

        foreach (vecs[k]) begin
            filter_mode_i = vecs[k].mode;
            trace_ready_i = vecs[k].ready;
            retire(vecs[k].v, vecs[k].pc, vecs[k].npc, vecs[k].rd, vecs[k].maddr,
                   vecs[k].rm, vecs[k].wm);
            tick();
            check($sformatf("vec%0d_valid", k), trace_valid_o, vecs[k].exp_valid);
            check($sformatf("vec%0d_level", k), fill_level_o, vecs[k].exp_level);
            if (vecs[k].exp_valid) begin
                check($sformatf("vec%0d_pc", k), trace_rec_o.pc, vecs[k].exp_pc);
                check($sformatf("vec%0d_insn", k), trace_rec_o.insn, insn_of(vecs[k].exp_pc));
                check($sformatf("vec%0d_wmask", k), trace_rec_o.wmask, vecs[k].exp_wm);
                check($sformatf("vec%0d_maddr", k), trace_rec_o.mem_addr, vecs[k].exp_maddr);
                check($sformatf("vec%0d_gap", k), trace_rec_o.gap, 0);
            end
        end
        check("vec_ovf", ovf_cnt_o, 0);

        // Trigger window 0x80..0x90, inclusive on both ends.
        idle_in();
        trace_en_i = 1'b0;
        tick();
        check("trig_idle0", trig_state_o, TrigIdle);
        trace_en_i      = 1'b1;
        trig_en_i       = 1'b1;
        trig_start_pc_i = 32'h80;
        trig_stop_pc_i  = 32'h90;
        filter_mode_i   = 2'd0;
        trace_ready_i   = 1'b0;
        trig_pcs = '{32'h7C, 32'h80, 32'h84, 32'h90, 32'h94};
        trig_exp = '{TrigIdle, TrigRun, TrigRun, TrigStopped, TrigStopped};
        trig_lvl = '{0, 1, 2, 3, 3};
        for (int i = 0; i < 5; i++) begin
            retire(1'b1, trig_pcs[i], trig_pcs[i] + 32'd4, 5'd1, 32'h0, 4'h0, 4'h0);
            tick();
            check($sformatf("trig_state%0d", i), trig_state_o, trig_exp[i]);
            check($sformatf("trig_level%0d", i), fill_level_o, trig_lvl[i]);
        end
        idle_in();
        trace_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check($sformatf("trig_out%0d", i), trace_rec_o.pc, trig_pcs[i]);
            tick();
        end
        check("trig_drained", trace_valid_o, 0);
        trace_en_i = 1'b0;
        tick();
        check("trig_toggle_idle", trig_state_o, TrigIdle);
        trace_en_i = 1'b1;
        tick();
        check("trig_reenable_idle", trig_state_o, TrigIdle);

        // Start PC equal to stop PC: exactly that one record, then STOPPED.
        trig_start_pc_i = 32'hA0;
        trig_stop_pc_i  = 32'hA0;
        retire(1'b1, 32'h9C, 32'hA0, 5'd1, 32'h0, 4'h0, 4'h0);
        tick();
        check("same_pre_valid", trace_valid_o, 0);
        retire(1'b1, 32'hA0, 32'hA4, 5'd1, 32'h0, 4'h0, 4'h0);
        tick();
        check("same_state", trig_state_o, TrigStopped);
        check("same_pc", trace_rec_o.pc, 32'hA0);
        retire(1'b1, 32'hA4, 32'hA8, 5'd1, 32'h0, 4'h0, 4'h0);
        tick();
        check("same_post_valid", trace_valid_o, 0);
        idle_in();
        trace_en_i = 1'b0;
        tick();
        trace_en_i = 1'b1;
        trig_en_i  = 1'b0;

        // Overflow: 20 retirements into 16 entries with the consumer stalled.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            retire(1'b1, 32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 5'd1, 32'h0, 4'h0, 4'h0);
            tick();
            if (i == 15) begin
                check("ovf_full_level", fill_level_o, 16);
                check("ovf_full_cnt", ovf_cnt_o, 0);
            end
        end
        idle_in();
        check("ovf_level", fill_level_o, 16);
        check("ovf_cnt", ovf_cnt_o, 4);
        check("ovf_head_pc", trace_rec_o.pc, 32'h1000);
        tick();
        check("ovf_stall_hold", trace_rec_o.pc, 32'h1000);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d_pc", i), trace_rec_o.pc, 32'h1000 + 32'(4 * i));
            tick();
        end
        check("drain_level", fill_level_o, 0);
        check("drain_ovf", ovf_cnt_o, 4);

        // First push after the drops carries gap=1, the one after does not.
        trace_ready_i = 1'b0;
        retire(1'b1, 32'h4000, 32'h4004, 5'd1, 32'h0, 4'h0, 4'h0);
        tick();
        check("gap_pc", trace_rec_o.pc, 32'h4000);
        check("gap_set", trace_rec_o.gap, 1);
        trace_ready_i = 1'b1;
        retire(1'b1, 32'h4004, 32'h4008, 5'd1, 32'h0, 4'h0, 4'h0);
        tick();
        check("gap_next_pc", trace_rec_o.pc, 32'h4004);
        check("gap_clear", trace_rec_o.gap, 0);
        check("gap_level", fill_level_o, 1);

        // Full with a simultaneous pop and retirement: no drop, level held.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            retire(1'b1, 32'h5000 + 32'(4 * i), 32'h5004 + 32'(4 * i), 5'd1, 32'h0, 4'h0, 4'h0);
            tick();
        end
        check("fp_pre_level", fill_level_o, 16);
        trace_ready_i = 1'b1;
        retire(1'b1, 32'h6000, 32'h6004, 5'd1, 32'h0, 4'h0, 4'h0);
        tick();
        check("fp_level", fill_level_o, 16);
        check("fp_ovf", ovf_cnt_o, 4);
        check("fp_head", trace_rec_o.pc, 32'h5000);

        // Asynchronous reset with 7 entries held.
        idle_in();
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        check("ar_pre_level", fill_level_o, 7);
        rst_ni = 1'b0;
        #2;
        check("ar_valid", trace_valid_o, 0);
        check("ar_level", fill_level_o, 0);
        check("ar_rec", trace_rec_o, 0);
        check("ar_ovf", ovf_cnt_o, 0);
        check("ar_state", trig_state_o, TrigIdle);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cve2_rvfi_trace_buffer.md
Name: cve2_rvfi_trace_buffer

Overview:
Hardware trace capture for the cve2 core. It snoops the RVFI retirement stream, filters records by a selectable mode, and gates capture with a PC start/stop trigger FSM. Accepted records go into a parametrised-depth FIFO, which is drained over a valid/ready stream. It sits beside the core in the tracing top, in parallel with the simulation tracer, and is synthesisable for on-chip debug.

Parameters:
Depth, 16, FIFO entries; power of two, at least 2.
OvfCntW, 16, width of the saturating dropped-record counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rvfi_valid  in  1  retirement strobe
rvfi_insn  in  32  retired instruction
rvfi_trap  in  1  trap flag
rvfi_intr  in  1  first instruction of a handler
rvfi_pc_rdata  in  32  PC of the retired instruction
rvfi_pc_wdata  in  32  next PC
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  32  destination write data
rvfi_mem_addr  in  32  memory address
rvfi_mem_rmask  in  4  load byte mask
rvfi_mem_wmask  in  4  store byte mask
trace_en_i  in  1  master enable
filter_mode_i  in  2  record filter (see Behaviour)
trig_en_i  in  1  1: use the PC trigger; 0: free-run
trig_start_pc_i  in  32  start PC
trig_stop_pc_i  in  32  stop PC
trace_valid_o  out  1  FIFO head valid
trace_ready_i  in  1  consumer ready
trace_rec_o  out  144  head record, type trace_rec_t
fill_level_o  out  $clog2(Depth+1)  current occupancy
ovf_cnt_o  out  OvfCntW  dropped-record count, saturating
trig_state_o  out  2  FSM state

Behaviour:
- Reset: FIFO empty. trace_valid_o=0, trace_rec_o=0, fill_level_o=0, ovf_cnt_o=0, trig_state_o=IDLE, gap_pending=0.
- Record fields, MSB to LSB: pc 32, insn 32, rd_addr 5, rd_wdata 32, mem_addr 32, rmask 4, wmask 4, trap 1, intr 1, gap 1. Total 144 bits.
- Filter hit (combinational on rvfi_*):
  - mode 0: all records.
  - mode 1: rmask|wmask != 0.
  - mode 2: trap | intr | (pc_wdata != pc_rdata+4 mod 2^32).
  - mode 3: rd_addr != 0.
- Trigger FSM, evaluated only on rvfi_valid:
  - States: IDLE=0, RUN=1, STOPPED=2.
  - trace_en_i=0 → IDLE from any state on the next clock.
  - trig_en_i=0 and trace_en_i=1 → RUN.
  - IDLE→RUN when pc_rdata == trig_start_pc_i; that record is eligible (inclusive).
  - RUN→STOPPED when pc_rdata == trig_stop_pc_i; that record is eligible (inclusive).
  - Start PC equal to stop PC on the same record → capture that one record, go to STOPPED.
  - STOPPED holds until trace_en_i drops.
- capture = rvfi_valid & trace_en_i & filter hit & (state==RUN or entering RUN) & not (state==STOPPED).
- Push: capture & (not full, or pop in the same cycle).
  - Full with a simultaneous pop: push and pop both occur, fill level unchanged.
- Drop: capture & full & no pop.
  - ovf_cnt_o increments, saturating at 2^OvfCntW-1.
  - gap_pending is set.
  - The next pushed record carries gap=1; gap_pending clears on that push.
  - Drop and push never coincide.
- Latency: a record pushed in cycle N is visible at the head in cycle N+1 if the FIFO was empty. There is no combinational path from rvfi_* to trace_*.
- Pop: trace_valid_o & trace_ready_i. trace_rec_o is stable while valid and not ready.
- Pointers are log2(Depth) bits and wrap modulo Depth. Full and empty are derived from an occupancy counter.
- trace_en_i deassertion does not flush the FIFO. Draining continues.
- Reset mid-operation discards all contents asynchronously.

Decomposition:
- Package cve2_trace_pkg holds:
  - trace_rec_t (packed struct);
  - trace_filter_e {TrAll, TrMem, TrCtrl, TrRegWr};
  - trig_state_e {TrigIdle, TrigRun, TrigStopped}.
- Sub-module cve2_trace_fifo: generic synchronous FIFO parametrised by Depth and element type/width. Provides push, pop, full, empty and level.
- Filter logic, trigger FSM and overflow logic stay in the top-level block.

Test Plan:
- mode 0, trig_en_i=0, 5 back-to-back retirements, ready=1 → 5 records out in order, each 1 cycle after its retirement; gap=0; ovf_cnt_o=0.
- mode 1, a stream of ALU/LW/SW/ALU with a SW at mem_addr 0x1000 and wmask 0xF → only the LW and SW are captured; the SW record has wmask=0xF and mem_addr=0x1000.
- trig_en_i=1, start 0x80, stop 0x90, PCs 0x7C, 0x80, 0x84, 0x90, 0x94 → records 0x80, 0x84, 0x90 captured; state ends STOPPED; toggling trace_en_i returns the FSM to IDLE.
- Depth=16, ready=0, 20 retirements → fill_level_o=16, ovf_cnt_o=4; drain, then one more push → that record has gap=1.
- FIFO full, ready=1 with a simultaneous retirement → fill level stays 16, no drop, ovf_cnt_o unchanged.
- Assert rst_ni low with 7 entries held → trace_valid_o=0 and fill_level_o=0 immediately, without waiting for a clock edge.
